stack_txn_queue: RTL

STACK_TXN_QUEUE -- requirements
Module: stack_txn_queue

---
 rtl/stack_cache_pkg.sv | 26 ++
 rtl/stack_txn_fifo.sv | 61 ++++++
 rtl/stack_txn_queue.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/stack_cache_pkg.sv
// Shared types and default sizing for the stack cache transaction queue.
// The optional rollback feature is enabled by STACK_TXN_ROLLBACK_EN.
package stack_cache_pkg;

  localparam int NUM_TAGS_D     = 16;
  localparam int ADDR_W_D       = 16;
  localparam int DATA_W_D       = 64;
  localparam int RD_DEPTH_D     = 4;
  localparam int WR_DEPTH_D     = 4;
  localparam int MAX_INFLIGHT_D = 4;
  localparam int TAG_W_D        = $clog2(NUM_TAGS_D);

  typedef logic [TAG_W_D-1:0] tag_t;

  typedef struct packed {
    logic [ADDR_W_D-1:0] addr;
    tag_t                tag;
  } rd_entry_t;

  typedef struct packed {
    logic [ADDR_W_D-1:0] addr;
    logic [DATA_W_D-1:0] data;
    tag_t                tag;
  } wr_entry_t;

endpackage

// File: rtl/stack_txn_fifo.sv
// Small register FIFO; the head entry is read straight from storage so it
// stays stable while the consumer stalls. Flush empties it in one cycle.
module stack_txn_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         sync_rst,
  input  logic         clk_en,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_push = clk_en && push && !full && !flush;
  assign do_pop  = clk_en && pop && !empty && !flush;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (!sync_rst) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else if (clk_en) begin
      if (flush) begin
        rptr <= '0;
        wptr <= '0;
        cnt  <= '0;
      end else begin
        if (do_push) wptr <= inc(wptr);
        if (do_pop)  rptr <= inc(rptr);
        cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/stack_txn_queue.sv
// Tag allocator plus fill/writeback issue queues for the stack cache.
// Optional rollback port and flush logic: define STACK_TXN_ROLLBACK_EN.
module stack_txn_queue
  import stack_cache_pkg::*;
#(
  parameter int NUM_TAGS     = NUM_TAGS_D,
  parameter int ADDR_W       = ADDR_W_D,
  parameter int DATA_W       = DATA_W_D,
  parameter int RD_DEPTH     = RD_DEPTH_D,
  parameter int WR_DEPTH     = WR_DEPTH_D,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_D
) (
  input  logic                          clk,
  input  logic                          sync_rst,
  input  logic                          clk_en,
`ifdef STACK_TXN_ROLLBACK_EN
  input  logic                          rollback_valid,
`endif
  input  logic                          alloc_valid,
  input  logic                          alloc_is_wr,
  input  logic [ADDR_W-1:0]             alloc_addr,
  input  logic [DATA_W-1:0]             alloc_data,
  output logic                          alloc_ready,
  output logic [$clog2(NUM_TAGS)-1:0]   alloc_tag,
  input  logic                          dirty_valid,
  input  logic [$clog2(NUM_TAGS)-1:0]   dirty_tag,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [ADDR_W-1:0]             rd_addr,
  output logic [$clog2(NUM_TAGS)-1:0]   rd_tag,
  input  logic                          rd_resp_valid,
  input  logic [$clog2(NUM_TAGS)-1:0]   rd_resp_tag,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [DATA_W-1:0]             wr_data,
  output logic [$clog2(NUM_TAGS)-1:0]   wr_tag,
  input  logic                          wr_ack_valid,
  input  logic [$clog2(NUM_TAGS)-1:0]   wr_ack_tag,
  output logic                          stack_dirty,
  output logic                          stack_to_be_read,
  output logic                          stack_to_be_written,
  output logic [$clog2(MAX_INFLIGHT):0] inflight_cnt
);

  localparam int TW = $clog2(NUM_TAGS);
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;
  localparam int RW = ADDR_W + TW;
  localparam int WW = ADDR_W + DATA_W + TW;

  logic [NUM_TAGS-1:0] dirty, tbr, tbw, free;
  logic [NUM_TAGS-1:0] dirty_n, tbr_n, tbw_n;
  logic [TW-1:0]       ptr, pick, idx;
  logic                found;
  logic                rd_full, rd_empty, wr_full, wr_empty;
  logic [RW-1:0]       rd_head;
  logic [WW-1:0]       wr_head;
  logic                rb_req, rb;
  logic                fill_fire, wb_fire, alloc_fire;
  logic                rd_fire, resp_ok, ack, dirty_set;

`ifdef STACK_TXN_ROLLBACK_EN
  logic [NUM_TAGS-1:0] queued, queued_n;
  assign rb_req = rollback_valid;
`else
  assign rb_req = 1'b0;
`endif
  assign rb = clk_en && rb_req;

  assign free = ~(tbr | tbw);

  // First free tag at or after the rotating pointer.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int i = 0; i < NUM_TAGS; i++) begin
      idx = ptr + TW'(i);
      if (!found && free[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign alloc_tag   = pick;
  assign alloc_ready = found && !rb_req &&
                       !(alloc_is_wr ? wr_full : rd_full);

  assign alloc_fire = clk_en && alloc_valid && alloc_ready;
  assign fill_fire  = alloc_fire && !alloc_is_wr;
  assign wb_fire    = alloc_fire && alloc_is_wr;
  assign rd_valid   = !rd_empty && (inflight_cnt < IW'(MAX_INFLIGHT));
  assign wr_valid   = !wr_empty;
  assign rd_fire    = clk_en && rd_valid && rd_ready;
  assign resp_ok    = clk_en && rd_resp_valid && (inflight_cnt != '0);
  assign ack        = clk_en && wr_ack_valid;
  assign dirty_set  = clk_en && dirty_valid;

`ifdef STACK_TXN_ROLLBACK_EN
  always_comb begin
    queued_n = queued;
    if (rd_fire)   queued_n[rd_tag] = 1'b0;
    if (fill_fire) queued_n[pick]   = 1'b1;
  end
`endif

  // Clears before sets, so a same-cycle dirty mark beats a write ack.
  always_comb begin
    tbr_n   = tbr;
    tbw_n   = tbw;
    dirty_n = dirty;
    if (resp_ok) tbr_n[rd_resp_tag] = 1'b0;
`ifdef STACK_TXN_ROLLBACK_EN
    if (rb) tbr_n = tbr_n & ~queued_n;
`endif
    if (fill_fire) tbr_n[pick] = 1'b1;
    if (ack) begin
      tbw_n[wr_ack_tag]   = 1'b0;
      dirty_n[wr_ack_tag] = 1'b0;
    end
    if (wb_fire)   tbw_n[pick]        = 1'b1;
    if (dirty_set) dirty_n[dirty_tag] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!sync_rst) begin
      dirty        <= '0;
      tbr          <= '0;
      tbw          <= '0;
      ptr          <= '0;
      inflight_cnt <= '0;
`ifdef STACK_TXN_ROLLBACK_EN
      queued       <= '0;
`endif
    end else if (clk_en) begin
      dirty <= dirty_n;
      tbr   <= tbr_n;
      tbw   <= tbw_n;
      if (alloc_fire) ptr <= pick + 1'b1;
      if (rd_fire && !resp_ok)      inflight_cnt <= inflight_cnt + 1'b1;
      else if (!rd_fire && resp_ok) inflight_cnt <= inflight_cnt - 1'b1;
`ifdef STACK_TXN_ROLLBACK_EN
      queued <= rb ? '0 : queued_n;
`endif
    end
  end

  stack_txn_fifo #(.W(RW), .DEPTH(RD_DEPTH)) u_rd_fifo (
    .clk     (clk),
    .sync_rst(sync_rst),
    .clk_en  (clk_en),
    .flush   (rb),
    .push    (fill_fire),
    .din     ({alloc_addr, pick}),
    .pop     (rd_fire),
    .dout    (rd_head),
    .empty   (rd_empty),
    .full    (rd_full)
  );

  stack_txn_fifo #(.W(WW), .DEPTH(WR_DEPTH)) u_wr_fifo (
    .clk     (clk),
    .sync_rst(sync_rst),
    .clk_en  (clk_en),
    .flush   (1'b0),
    .push    (wb_fire),
    .din     ({alloc_addr, alloc_data, pick}),
    .pop     (wr_valid && wr_ready),
    .dout    (wr_head),
    .empty   (wr_empty),
    .full    (wr_full)
  );

  assign rd_addr = rd_head[RW-1:TW];
  assign rd_tag  = rd_head[TW-1:0];
  assign wr_addr = wr_head[WW-1 -: ADDR_W];
  assign wr_data = wr_head[TW +: DATA_W];
  assign wr_tag  = wr_head[TW-1:0];

  assign stack_dirty         = |dirty;
  assign stack_to_be_read    = |tbr;
  assign stack_to_be_written = |tbw;

endmodule
